// File: rtl/input_word_packer.sv
// Packs a byte-counted narrow input stream into OUT_BYTES-wide words, flags the
// final word of each block with out_delim and tags every word with a head address.
module input_word_packer #(
  parameter int IN_BYTES   = 8,
  parameter int OUT_BYTES  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_BYTES*8-1:0]        in_data,
  input  logic [$clog2(IN_BYTES):0]    in_nbytes,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_BYTES*8-1:0]       out_data,
  output logic [$clog2(OUT_BYTES):0]   out_nbytes,
  output logic                         out_delim,
  output logic [ADDR_WIDTH-1:0]        out_head_addr
);

  localparam int TOT_BYTES = OUT_BYTES + IN_BYTES;
  localparam int FW        = $clog2(TOT_BYTES + 1);
  localparam int INW       = $clog2(IN_BYTES) + 1;
  localparam int ONW       = $clog2(OUT_BYTES) + 1;

  typedef enum logic {
    ST_ACCUM,
    ST_FLUSH
  } state_e;

  state_e                  state_q, state_d;
  logic [TOT_BYTES*8-1:0]  acc_q, acc_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [ADDR_WIDTH-1:0]   head_q, head_d;

  logic                    fill_le_out;
  logic                    fill_ge_out;
  logic                    in_hs;
  logic                    out_hs;
  logic [FW-1:0]           nb;
  logic [IN_BYTES*8-1:0]   masked;
  logic [TOT_BYTES*8-1:0]  ext;

  // Outputs decode only registered state; out_ready never reaches in_ready.
  always_comb begin
    fill_le_out   = (fill_q <= FW'(OUT_BYTES));
    fill_ge_out   = (fill_q >= FW'(OUT_BYTES));
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_delim     = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in_ready  = !rst && fill_le_out;
        out_valid = fill_ge_out;
      end
      ST_FLUSH: begin
        out_valid = 1'b1;
        out_delim = fill_le_out;
      end
      default: ;
    endcase
    out_data      = acc_q[OUT_BYTES*8-1:0];
    out_nbytes    = fill_le_out ? ONW'(fill_q) : ONW'(OUT_BYTES);
    out_head_addr = head_q;
  end

  always_comb begin
    in_hs   = in_valid && in_ready;
    out_hs  = out_valid && out_ready;
    nb      = (in_nbytes > INW'(IN_BYTES)) ? FW'(IN_BYTES) : FW'(in_nbytes);
    masked  = '0;
    for (int unsigned i = 0; i < IN_BYTES; i++) begin
      if (FW'(i) < nb) masked[i*8 +: 8] = in_data[i*8 +: 8];
    end

    acc_d   = acc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    state_d = state_q;

    if (out_hs) begin
      acc_d  = acc_q >> (OUT_BYTES*8);
      fill_d = fill_le_out ? '0 : fill_q - FW'(OUT_BYTES);
      head_d = head_q + ADDR_WIDTH'(OUT_BYTES);
    end

    // Bytes at and above fill are always zero, so OR-ing the shifted beat in
    // at the post-shift fill is an append that leaves the held word intact.
    ext = {{(OUT_BYTES*8){1'b0}}, masked} << {fill_d, 3'b000};

    if (in_hs) begin
      acc_d  = acc_d | ext;
      fill_d = fill_d + nb;
      if (in_last) state_d = ST_FLUSH;
    end

    if ((state_q == ST_FLUSH) && out_hs && fill_le_out) state_d = ST_ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      fill_q  <= '0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: doc/input_word_packer.md
# input_word_packer

Upstream producer for the hash engine input port. Collects a narrow, byte-counted input stream into HASH_ISSUE_WIDTH-byte words, marks the final word of every data block with `out_delim`, and tags each word with a running head address. It sits between the host/DMA ingress and the leftover buffer that builds the overlapping hash windows.

## Interface
- `IN_BYTES`, default 8: bytes per input beat; 1 ≤ IN_BYTES ≤ OUT_BYTES.
- `OUT_BYTES`, default 16: bytes per output word; equals HASH_ISSUE_WIDTH.
- `ADDR_WIDTH`, default 32: head address width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when valid && ready.
- `in_data` in IN_BYTES*8: beat data; byte 0 in bits [7:0]; valid bytes are low-aligned.
- `in_nbytes` in $clog2(IN_BYTES)+1: count of valid bytes in the beat, 0..IN_BYTES; values above IN_BYTES are treated as IN_BYTES.
- `in_last` in 1: beat ends the current block.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: output word consumed when valid && ready.
- `out_data` out OUT_BYTES*8: packed word; unused bytes are zero.
- `out_nbytes` out $clog2(OUT_BYTES)+1: valid bytes in the word; equals OUT_BYTES except on a delim word.
- `out_delim` out 1: word is the last of its block.
- `out_head_addr` out ADDR_WIDTH: stream address of byte 0 of the word.

## Operation
- Accumulator: OUT_BYTES+IN_BYTES bytes plus a `fill` byte count. Word output always comes from accumulator bytes [0..OUT_BYTES-1].
- States: ACCUM and FLUSH.
- In ACCUM:
  - `in_ready` = (fill ≤ OUT_BYTES). It does not depend on `out_ready`.
  - `out_valid` = (fill ≥ OUT_BYTES).
  - `out_delim` = 0.
- On input handshake:
  - Append in_nbytes bytes at accumulator offset fill−c, where c = OUT_BYTES if an output handshake occurs in the same cycle, else 0.
  - New fill = fill − c + in_nbytes.
  - If in_last, go to FLUSH.
  - A beat with in_nbytes=0 and in_last=0 is accepted with no effect.
- On output handshake: shift the accumulator down by OUT_BYTES, zero-fill the top, and fill −= min(fill, OUT_BYTES).
- In FLUSH:
  - `in_ready` = 0 and `out_valid` = 1.
  - If fill > OUT_BYTES: emit a full word with `out_delim` = 0 and stay in FLUSH.
  - Otherwise: emit the final word with `out_delim` = 1, `out_nbytes` = fill, and bytes ≥ fill zero. After its handshake, set fill = 0 and return to ACCUM.
- Zero-length block (in_last with nothing buffered): emit one all-zero word with `out_nbytes` = 0 and `out_delim` = 1.
- `out_head_addr` advances by OUT_BYTES on every output handshake, including delim and partial words. It wraps modulo 2^ADDR_WIDTH and resets only on `rst`. Consequence: a block always starts at an OUT_BYTES-aligned address.
- Output stability: while out_valid && !out_ready, `out_data`, `out_nbytes`, `out_delim` and `out_head_addr` hold. Input appends write only bytes at offsets ≥ fill.

## Timing
- Reset (async assert, sync-safe release):
  - state = ACCUM, fill = 0, accumulator = 0, head addr = 0.
  - Outputs: `out_valid` 0, `in_ready` 0 while rst is high, `out_data` 0, `out_nbytes` 0, `out_delim` 0, `out_head_addr` 0.
  - `in_ready` = 1 in the first cycle after release.
- Reset mid-operation discards all buffered bytes and any pending FLUSH. No word is emitted afterwards for that data.
- Latency: `out_valid` rises in the cycle after the input handshake that makes fill ≥ OUT_BYTES or carries in_last.
- Throughput: sustains OUT_BYTES/IN_BYTES input beats per output word with no bubbles when out_ready = 1 and in_nbytes = IN_BYTES. This holds because of the simultaneous in/out handshake.
- FLUSH costs 1 or 2 output cycles. Input stalls for that duration.
- No combinational path from `out_ready` to `in_ready`. All outputs are register-driven.

## Test plan
- **Full beats, aligned block** (IN=8, OUT=16). Input: four beats, bytes 0x00..0x1F, in_last on beat 4, out_ready=1.
  - Expected: words 0x00..0x0F at addr 0 and 0x10..0x1F at addr 16. The second word has delim=1 and nbytes=16. No input stall.
- **Partial tail.** Input: beats of 8, 8, 3 bytes, last on the third.
  - Expected: word0 full (addr 0), then word1 with nbytes=3, delim=1, bytes 3..15 zero, addr 16. The next block's first word is at addr 32.
- **Variable nbytes packing.** Input: beats of 5, 0, 8, 7, 6 bytes, then last.
  - Expected: the byte sequence is preserved contiguously across words: 16 bytes, then delim word with nbytes=10. The 0-byte beat is accepted and ignored.
- **Zero-length block.** Input: in_last with in_nbytes=0 on an empty accumulator.
  - Expected: one word with data=0, nbytes=0, delim=1, and head addr advances by 16.
- **Backpressure.** Hold out_ready=0 for 10 cycles with in_valid=1.
  - Expected: in_ready drops once fill > 16. Outputs stay stable. No byte is lost or duplicated after release.
- **Reset mid-FLUSH.** Assert rst while out_valid=1 and delim is pending.
  - Expected: out_valid=0 immediately (async). After release, the first word is at addr 0 and no delim word is emitted.
